// File: rtl/student_record_parser.sv
// ---------------------------------------------------------------------------
// student_record_parser
//
// Turns an ASCII stream of student records into the feature vector used by
// the decision-tree stage. Each record is one line of the form
//     f1,f2,f3,f4,f5,f6<LF>
// where f1/f3 are integers, f2 is a percentage with an optional fraction,
// f4 is a single digit 0-3, and f5/f6 are 'Y' or 'N'. CR bytes are ignored.
// A good record is presented for one cycle on feat_valid; a bad record is
// dropped through to its LF, reported on rec_error and counted.
//
// Ports
//   clk, reset        : rising-edge clock, async active-high reset
//   in_data/in_valid  : byte stream in; transfer when in_valid && in_ready
//   in_ready          : low only while reset is asserted or in EMIT
//   study_hours       : field 1
//   attendance        : field 2 as percent*10^FRAC_DIGITS, clamped to ATT_MAX
//   past_scores       : field 3
//   parental_edu      : field 4
//   internet_access   : field 5 ('Y'=1)
//   extracurricular   : field 6 ('Y'=1)
//   feat_valid        : one-cycle strobe, new vector on the feature outputs
//   rec_error         : one-cycle strobe, a record was rejected
//   rec_count         : good-record count (wraps)
//   err_count         : rejected-record count (wraps)
//
// state   | meaning
// --------+----------------------------------------------------------------
// INT     | accumulating integer digits / single-char fields (idx 0-5)
// FRAC    | accumulating attendance fraction digits (idx 1)
// DISCARD | record is bad, dropping bytes up to and including the LF
// EMIT    | one cycle: vector and strobe are out, input stalled
// ---------------------------------------------------------------------------
module student_record_parser #(
    parameter int DATA_W      = 16,
    parameter int FRAC_DIGITS = 2,
    parameter int ATT_MAX     = 9999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] study_hours,
    output logic [DATA_W-1:0] attendance,
    output logic [DATA_W-1:0] past_scores,
    output logic [1:0]        parental_edu,
    output logic              internet_access,
    output logic              extracurricular,
    output logic              feat_valid,
    output logic              rec_error,
    output logic [DATA_W-1:0] rec_count,
    output logic [DATA_W-1:0] err_count
);

    localparam int ACC_W     = DATA_W + 1;
    localparam int MAC_W     = ACC_W + 4;
    localparam int ATT_SCALE = 10 ** FRAC_DIGITS;
    localparam logic [MAC_W-1:0] FIELD_MAX = MAC_W'((64'd1 << DATA_W) - 64'd1);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_N     = 8'h4E;

    typedef enum logic [1:0] {
        ST_INT,
        ST_FRAC,
        ST_DISCARD,
        ST_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          fidx_q, fidx_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                have_q, have_d;        // current field has content
    logic [DATA_W-1:0]   att_int_q, att_int_d;  // attendance integer part
    logic [15:0]         frac_q, frac_d;
    logic [3:0]          frac_cnt_q, frac_cnt_d;

    // Staging for the record in progress; copied to outputs only on EMIT.
    logic [DATA_W-1:0]   f1_st_q, f1_st_d;
    logic [DATA_W-1:0]   att_st_q, att_st_d;
    logic [DATA_W-1:0]   f3_st_q, f3_st_d;
    logic [1:0]          f4_st_q, f4_st_d;
    logic                f5_st_q, f5_st_d;
    logic                f6_st_q, f6_st_d;

    logic [DATA_W-1:0]   study_hours_q, study_hours_d;
    logic [DATA_W-1:0]   attendance_q, attendance_d;
    logic [DATA_W-1:0]   past_scores_q, past_scores_d;
    logic [1:0]          parental_edu_q, parental_edu_d;
    logic                internet_access_q, internet_access_d;
    logic                extracurricular_q, extracurricular_d;
    logic                feat_valid_q, feat_valid_d;
    logic                rec_error_q, rec_error_d;
    logic [DATA_W-1:0]   rec_count_q, rec_count_d;
    logic [DATA_W-1:0]   err_count_q, err_count_d;

    logic                take;
    logic                is_digit;
    logic                is_yn;
    logic [3:0]          digit;
    logic [MAC_W-1:0]    acc_mac;
    logic                acc_ovf;
    logic                bad;
    logic                emit;

    // Attendance = int*10^FRAC_DIGITS + fraction, with absent fraction
    // digits treated as trailing zeros, clamped to ATT_MAX.
    function automatic logic [DATA_W-1:0] scale_att(
        input logic [DATA_W-1:0] ip,
        input logic [15:0]       fr,
        input logic [3:0]        cnt
    );
        logic [39:0] pad;
        logic [39:0] full;
        pad = 40'(fr);
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            if (i >= int'(cnt)) pad = pad * 40'd10;
        end
        full = 40'(ip) * 40'(ATT_SCALE) + pad;
        if (full > 40'(ATT_MAX)) return DATA_W'(ATT_MAX);
        return full[DATA_W-1:0];
    endfunction

    assign in_ready = (state_q != ST_EMIT) && !reset;
    assign take     = in_valid && in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_yn    = (in_data == CH_Y) || (in_data == CH_N);
    assign digit    = in_data[3:0];
    assign acc_mac  = MAC_W'(acc_q) * MAC_W'(10) + MAC_W'(digit);
    assign acc_ovf  = acc_mac > FIELD_MAX;

    always_comb begin
        state_d           = state_q;
        fidx_d            = fidx_q;
        acc_d             = acc_q;
        have_d            = have_q;
        att_int_d         = att_int_q;
        frac_d            = frac_q;
        frac_cnt_d        = frac_cnt_q;
        f1_st_d           = f1_st_q;
        att_st_d          = att_st_q;
        f3_st_d           = f3_st_q;
        f4_st_d           = f4_st_q;
        f5_st_d           = f5_st_q;
        f6_st_d           = f6_st_q;
        study_hours_d     = study_hours_q;
        attendance_d      = attendance_q;
        past_scores_d     = past_scores_q;
        parental_edu_d    = parental_edu_q;
        internet_access_d = internet_access_q;
        extracurricular_d = extracurricular_q;
        feat_valid_d      = 1'b0;
        rec_error_d       = 1'b0;
        rec_count_d       = rec_count_q;
        err_count_d       = err_count_q;
        bad               = 1'b0;
        emit              = 1'b0;

        if (take) begin
            unique case (state_q)
                ST_INT: begin
                    if (in_data == CH_CR) begin
                        // ignored
                    end else if (in_data == CH_LF) begin
                        if (fidx_q == 3'd5 && have_q) begin
                            emit = 1'b1;
                        end else if (!(fidx_q == 3'd0 && !have_q)) begin
                            bad = 1'b1;
                        end
                        // a bare LF falls through with nothing to do
                    end else if (in_data == CH_COMMA) begin
                        if (!have_q || fidx_q == 3'd5) begin
                            bad = 1'b1;
                        end else begin
                            unique case (fidx_q)
                                3'd0:    f1_st_d  = acc_q[DATA_W-1:0];
                                3'd1:    att_st_d = scale_att(acc_q[DATA_W-1:0], 16'd0, 4'd0);
                                3'd2:    f3_st_d  = acc_q[DATA_W-1:0];
                                3'd3:    f4_st_d  = acc_q[1:0];
                                default: ;
                            endcase
                            fidx_d = fidx_q + 3'd1;
                            acc_d  = '0;
                            have_d = 1'b0;
                        end
                    end else if (in_data == CH_DOT) begin
                        if (fidx_q == 3'd1 && have_q) begin
                            att_int_d  = acc_q[DATA_W-1:0];
                            frac_d     = '0;
                            frac_cnt_d = '0;
                            state_d    = ST_FRAC;
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (is_digit) begin
                        if (fidx_q <= 3'd2) begin
                            if (acc_ovf) begin
                                bad = 1'b1;
                            end else begin
                                acc_d  = acc_mac[ACC_W-1:0];
                                have_d = 1'b1;
                            end
                        end else if (fidx_q == 3'd3) begin
                            if (have_q || digit > 4'd3) begin
                                bad = 1'b1;
                            end else begin
                                acc_d  = ACC_W'(digit);
                                have_d = 1'b1;
                            end
                        end else begin
                            bad = 1'b1;
                        end
                    end else if (is_yn) begin
                        if (fidx_q == 3'd4 && !have_q) begin
                            f5_st_d = (in_data == CH_Y);
                            have_d  = 1'b1;
                        end else if (fidx_q == 3'd5 && !have_q) begin
                            f6_st_d = (in_data == CH_Y);
                            have_d  = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end

                ST_FRAC: begin
                    if (in_data == CH_CR) begin
                        // ignored
                    end else if (is_digit) begin
                        // digits past the kept precision are truncated
                        if (int'(frac_cnt_q) < FRAC_DIGITS) begin
                            frac_d     = 16'(frac_q * 16'd10 + 16'(digit));
                            frac_cnt_d = frac_cnt_q + 4'd1;
                        end
                    end else if (in_data == CH_COMMA) begin
                        att_st_d = scale_att(att_int_q, frac_q, frac_cnt_q);
                        fidx_d   = 3'd2;
                        acc_d    = '0;
                        have_d   = 1'b0;
                        state_d  = ST_INT;
                    end else begin
                        bad = 1'b1;
                    end
                end

                ST_DISCARD: begin
                    if (in_data == CH_LF) begin
                        rec_error_d = 1'b1;
                        err_count_d = err_count_q + DATA_W'(1);
                        fidx_d      = '0;
                        acc_d       = '0;
                        have_d      = 1'b0;
                        state_d     = ST_INT;
                    end
                end

                default: ;
            endcase
        end

        // An error found on the LF itself closes the record right away;
        // otherwise the rest of the line still has to be skipped.
        if (bad) begin
            if (in_data == CH_LF) begin
                rec_error_d = 1'b1;
                err_count_d = err_count_q + DATA_W'(1);
                fidx_d      = '0;
                acc_d       = '0;
                have_d      = 1'b0;
                state_d     = ST_INT;
            end else begin
                state_d = ST_DISCARD;
            end
        end

        if (emit) begin
            study_hours_d     = f1_st_q;
            attendance_d      = att_st_q;
            past_scores_d     = f3_st_q;
            parental_edu_d    = f4_st_q;
            internet_access_d = f5_st_q;
            extracurricular_d = f6_st_q;
            feat_valid_d      = 1'b1;
            rec_count_d       = rec_count_q + DATA_W'(1);
            fidx_d            = '0;
            acc_d             = '0;
            have_d            = 1'b0;
            state_d           = ST_EMIT;
        end

        if (state_q == ST_EMIT) state_d = ST_INT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_INT;
            fidx_q            <= '0;
            acc_q             <= '0;
            have_q            <= 1'b0;
            att_int_q         <= '0;
            frac_q            <= '0;
            frac_cnt_q        <= '0;
            f1_st_q           <= '0;
            att_st_q          <= '0;
            f3_st_q           <= '0;
            f4_st_q           <= '0;
            f5_st_q           <= 1'b0;
            f6_st_q           <= 1'b0;
            study_hours_q     <= '0;
            attendance_q      <= '0;
            past_scores_q     <= '0;
            parental_edu_q    <= '0;
            internet_access_q <= 1'b0;
            extracurricular_q <= 1'b0;
            feat_valid_q      <= 1'b0;
            rec_error_q       <= 1'b0;
            rec_count_q       <= '0;
            err_count_q       <= '0;
        end else begin
            state_q           <= state_d;
            fidx_q            <= fidx_d;
            acc_q             <= acc_d;
            have_q            <= have_d;
            att_int_q         <= att_int_d;
            frac_q            <= frac_d;
            frac_cnt_q        <= frac_cnt_d;
            f1_st_q           <= f1_st_d;
            att_st_q          <= att_st_d;
            f3_st_q           <= f3_st_d;
            f4_st_q           <= f4_st_d;
            f5_st_q           <= f5_st_d;
            f6_st_q           <= f6_st_d;
            study_hours_q     <= study_hours_d;
            attendance_q      <= attendance_d;
            past_scores_q     <= past_scores_d;
            parental_edu_q    <= parental_edu_d;
            internet_access_q <= internet_access_d;
            extracurricular_q <= extracurricular_d;
            feat_valid_q      <= feat_valid_d;
            rec_error_q       <= rec_error_d;
            rec_count_q       <= rec_count_d;
            err_count_q       <= err_count_d;
        end
    end

    assign study_hours     = study_hours_q;
    assign attendance      = attendance_q;
    assign past_scores     = past_scores_q;
    assign parental_edu    = parental_edu_q;
    assign internet_access = internet_access_q;
    assign extracurricular = extracurricular_q;
    assign feat_valid      = feat_valid_q;
    assign rec_error       = rec_error_q;
    assign rec_count       = rec_count_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_student_record_parser.sv
// ---------------------------------------------------------------------------
// Bench for student_record_parser. Stimulus pushes the hand-computed
// expected strobe (good vector or rejection, with the outputs that must be
// visible and both counters) into a queue; an independent monitor pops and
// compares on every feat_valid / rec_error strobe.
// ---------------------------------------------------------------------------
module tb_student_record_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] study_hours, attendance, past_scores;
    logic [1:0]  parental_edu;
    logic        internet_access, extracurricular;
    logic        feat_valid, rec_error;
    logic [15:0] rec_count, err_count;

    student_record_parser dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .study_hours     (study_hours),
        .attendance      (attendance),
        .past_scores     (past_scores),
        .parental_edu    (parental_edu),
        .internet_access (internet_access),
        .extracurricular (extracurricular),
        .feat_valid      (feat_valid),
        .rec_error       (rec_error),
        .rec_count       (rec_count),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [15:0] sh, att, ps;
        logic [1:0]  pe;
        logic        ia, xc;
        logic [15:0] rc, erc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;
    bit          count_stall = 0;

    // model of what the outputs must currently hold
    logic [15:0] h_sh, h_att, h_ps, m_rc, m_erc;
    logic [1:0]  h_pe;
    logic        h_ia, h_xc;

    task automatic model_reset();
        h_sh = 0; h_att = 0; h_ps = 0; h_pe = 0; h_ia = 0; h_xc = 0;
        m_rc = 0; m_erc = 0;
    endtask

    task automatic push_good(input logic [15:0] sh, input logic [15:0] att,
                             input logic [15:0] ps, input logic [1:0] pe,
                             input logic ia, input logic xc);
        exp_t e;
        h_sh = sh; h_att = att; h_ps = ps; h_pe = pe; h_ia = ia; h_xc = xc;
        m_rc = m_rc + 16'd1;
        e.is_err = 0; e.sh = sh; e.att = att; e.ps = ps; e.pe = pe;
        e.ia = ia; e.xc = xc; e.rc = m_rc; e.erc = m_erc;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        m_erc = m_erc + 16'd1;
        e.is_err = 1; e.sh = h_sh; e.att = h_att; e.ps = h_ps; e.pe = h_pe;
        e.ia = h_ia; e.xc = h_xc; e.rc = m_rc; e.erc = m_erc;
        q.push_back(e);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (count_stall && in_valid && !in_ready) stall_cnt++;
            if (feat_valid || rec_error) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_strobe got fv=%0b re=%0b want none",
                             feat_valid, rec_error);
                end else begin
                    mon_e = q.pop_front();
                    if (feat_valid !== !mon_e.is_err || rec_error !== mon_e.is_err ||
                        study_hours !== mon_e.sh || attendance !== mon_e.att ||
                        past_scores !== mon_e.ps || parental_edu !== mon_e.pe ||
                        internet_access !== mon_e.ia || extracurricular !== mon_e.xc ||
                        rec_count !== mon_e.rc || err_count !== mon_e.erc) begin
                        n_errors++;
                        $display("FAIL strobe got fv=%0b re=%0b %0d/%0d/%0d/%0d/%0b/%0b rc=%0d ec=%0d want fv=%0b re=%0b %0d/%0d/%0d/%0d/%0b/%0b rc=%0d ec=%0d",
                                 feat_valid, rec_error, study_hours, attendance, past_scores,
                                 parental_edu, internet_access, extracurricular, rec_count, err_count,
                                 !mon_e.is_err, mon_e.is_err, mon_e.sh, mon_e.att, mon_e.ps,
                                 mon_e.pe, mon_e.ia, mon_e.xc, mon_e.rc, mon_e.erc);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        bit done;
        done = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout byte=%02h got no in_ready want accepted", b);
        end
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s, input int max_gap, input bit keep_valid);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if (study_hours !== 0 || attendance !== 0 || past_scores !== 0 ||
            parental_edu !== 0 || internet_access !== 0 || extracurricular !== 0 ||
            feat_valid !== 0 || rec_error !== 0 || rec_count !== 0 || err_count !== 0) begin
            n_errors++;
            $display("FAIL %s_outputs got %0d/%0d/%0d/%0d/%0b/%0b fv=%0b re=%0b rc=%0d ec=%0d want all zero",
                     tag, study_hours, attendance, past_scores, parental_edu, internet_access,
                     extracurricular, feat_valid, rec_error, rec_count, err_count);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_in_ready got %0b want 0", tag, in_ready);
        end
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_ready_after got %0b want 1", tag, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("por");
        release_reset("por");

        // basic record
        push_good(16'd31, 16'd6826, 16'd86, 2'd0, 1'b1, 1'b1);
        send_str("31,68.26,86,0,Y,Y\n", 0, 0);
        wait_drain();

        // CR and idle gaps, then fraction truncation
        push_good(16'd16, 16'd7820, 16'd73, 2'd3, 1'b0, 1'b0);
        send_str("16,78.2,73,3,N,N\r\n", 3, 0);
        wait_drain();
        push_good(16'd21, 16'd8752, 16'd74, 2'd3, 1'b1, 1'b0);
        send_str("21,87.525,74,3,Y,N\n", 2, 0);
        wait_drain();

        // clamp
        push_good(16'd37, 16'd9999, 16'd63, 2'd2, 1'b0, 1'b1);
        send_str("37,100,63,2,N,Y\n", 0, 0);
        wait_drain();

        // rejects: outputs must keep the 37/9999/63 vector
        push_err(); send_str("14,84.35,94,4,Y,Y\n", 0, 0);
        push_err(); send_str("70000,1,1,1,Y,Y\n", 1, 0);
        push_err(); send_str("5,1,1\n", 0, 0);
        wait_drain();
        push_err(); send_str("1,2.3.4,5,0,Y,Y\n", 0, 0);
        push_err(); send_str("1,2,3,0,Y,Y,N\n", 0, 0);
        push_err(); send_str("1,2,3,0,y,Y\n", 0, 0);
        push_err(); send_str("1, 2,3,0,Y,Y\n", 0, 0);
        send_str("\r\n", 0, 0);
        push_err(); send_str(",2,3,0,Y,Y\n", 0, 0);
        wait_drain();

        // fraction padding: ".5" -> 50, "5." -> 500
        push_good(16'd1, 16'd50, 16'd2, 2'd1, 1'b0, 1'b1);
        send_str("1,0.5,2,1,N,Y\n", 0, 0);
        push_good(16'd2, 16'd500, 16'd3, 2'd0, 1'b1, 1'b0);
        send_str("2,5.,3,0,Y,N\n", 0, 0);
        wait_drain();

        // reset in the middle of a record
        send_str("31,68", 0, 0);
        #3;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_state("mid");
        release_reset("mid");
        push_good(16'd14, 16'd8435, 16'd94, 2'd0, 1'b1, 1'b1);
        send_str("14,84.35,94,0,Y,Y\n", 0, 0);
        wait_drain();

        // continuous stream: stalls only in the two EMIT cycles
        count_stall = 1;
        push_good(16'd1, 16'd200, 16'd3, 2'd1, 1'b1, 1'b0);
        push_good(16'd65535, 16'd0, 16'd65535, 2'd1, 1'b1, 1'b1);
        send_str("1,2,3,1,Y,N\n", 0, 1);
        send_str("65535,0,65535,1,Y,Y\n", 0, 1);
        send_str("\n", 0, 0);
        count_stall = 0;
        wait_drain();
        n_checks++;
        if (stall_cnt != 2) begin
            n_errors++;
            $display("FAIL stall_cycles got %0d want 2", stall_cnt);
        end

        repeat (10) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_expected got %0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
